// File: rtl/ms_timer_sched.sv
// Four-channel millisecond one-shot timer scheduler with round-robin load arbitration
// and a shared prescaler that only runs while at least one channel is busy.
module ms_timer_sched #(
    parameter int unsigned T     = 100000,
    parameter int unsigned DUR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*DUR_W-1:0] dur,
    input  logic [3:0]         cancel,
    output logic [3:0]         gnt,
    output logic [3:0]         busy,
    output logic [3:0]         done,
    output logic               tick
);

    localparam int unsigned    PW      = $clog2(T);
    localparam logic [PW-1:0]  PRE_MAX = PW'(T - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       busy_q, busy_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       done_q, done_d;
    logic [DUR_W-1:0] rem_q [4];
    logic [DUR_W-1:0] rem_d [4];

    logic [3:0] elig;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       any_busy;

    assign any_busy = |busy_q;
    assign tick     = any_busy && (pre_q == PRE_MAX);
    assign elig     = req & ~busy_q;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if ((grant == '0) && elig[idx]) begin
                grant[idx] = 1'b1;
                ptr_d      = idx;
            end
        end
    end

    // Cancel is checked before expiry so an aborted channel never reports done;
    // a freshly granted channel is idle this cycle and so skips the tick.
    always_comb begin
        busy_d = busy_q;
        done_d = '0;
        gnt_d  = grant;
        for (int unsigned i = 0; i < 4; i++) begin
            rem_d[i] = rem_q[i];
            if (busy_q[i]) begin
                if (cancel[i]) begin
                    busy_d[i] = 1'b0;
                end else if (tick) begin
                    if (rem_q[i] <= DUR_W'(1)) begin
                        busy_d[i] = 1'b0;
                        done_d[i] = 1'b1;
                    end else begin
                        rem_d[i] = rem_q[i] - DUR_W'(1);
                    end
                end
            end else if (grant[i]) begin
                busy_d[i] = 1'b1;
                if (dur[i*DUR_W +: DUR_W] == '0) begin
                    rem_d[i] = DUR_W'(1);
                end else begin
                    rem_d[i] = dur[i*DUR_W +: DUR_W];
                end
            end
        end
    end

    // Starting from all-idle keeps the prescaler at 0 so the first ms is a full period.
    always_comb begin
        if ((busy_d == '0) || !any_busy) begin
            pre_d = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            ptr_q  <= 2'd3;
            busy_q <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            gnt_q  <= gnt_d;
            done_q <= done_d;
            for (int unsigned i = 0; i < 4; i++) begin
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ms_timer_sched.sv
// Directed self-checking bench for ms_timer_sched with T=10, DUR_W=16.
module tb_ms_timer_sched;

    localparam int unsigned T     = 10;
    localparam int unsigned DUR_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [4*DUR_W-1:0] dur;
    logic [3:0]         cancel;
    logic [3:0]         gnt;
    logic [3:0]         busy;
    logic [3:0]         done;
    logic               tick;

    int checks = 0;
    int errors = 0;

    ms_timer_sched #(.T(T), .DUR_W(DUR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dur    (dur),
        .cancel (cancel),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int ch, input int budget, output int cnt, output int nt);
        cnt = 0;
        nt  = 0;
        while ((done[ch] !== 1'b1) && (cnt < budget)) begin
            if (tick === 1'b1) nt++;
            step();
            cnt++;
        end
    endtask

    task automatic wait_any_done(input int budget, output int cnt);
        cnt = 0;
        while ((done === 4'b0000) && (cnt < budget)) begin
            step();
            cnt++;
        end
    endtask

    task automatic set_dur(input int ch, input logic [DUR_W-1:0] d);
        dur[ch*DUR_W +: DUR_W] = d;
    endtask

    initial begin
        int cnt;
        int nt;
        int seen_done;

        rst    = 1'b1;
        req    = '0;
        dur    = '0;
        cancel = '0;
        step();
        step();
        chk("reset_gnt",  32'(gnt),  32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        rst = 1'b0;

        // 1. Reset mid-count, then a single 3 ms start
        set_dur(0, 16'd5);
        req = 4'b0001;
        step();
        req = '0;
        repeat (4) step();
        chk("pre_reset_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_pre",  32'(dut.pre_q), 32'h0);
        step();
        rst = 1'b0;

        set_dur(0, 16'd3);
        req = 4'b0001;
        chk("gnt_before_edge", 32'(gnt), 32'h0);
        step();
        chk("t1_gnt0",  32'(gnt),  32'h1);
        chk("t1_busy0", 32'(busy), 32'h1);
        req = '0;
        step();
        chk("t1_gnt_pulse", 32'(gnt), 32'h0);
        wait_done(0, 60, cnt, nt);
        chk("t1_done_latency", 32'(cnt + 1), 32'd30);
        chk("t1_tick_count",   32'(nt), 32'd3);
        chk("t1_busy_fall",    32'(busy), 32'h0);
        chk("t1_pre_zero",     32'(dut.pre_q), 32'h0);
        step();
        chk("t1_done_pulse", 32'(done), 32'h0);

        // 2. Contention from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) set_dur(c, 16'd2);
        req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t2_rr_gnt%0d", c), 32'(gnt), 32'(4'b0001 << c));
            req = req & ~gnt;
        end
        wait_any_done(40, cnt);
        chk("t2_all_done_latency", 32'(cnt), 32'd17);
        chk("t2_all_done_same",    32'(done), 32'hF);
        req = 4'b0101;
        step();
        chk("t2_rr_second_0", 32'(gnt), 32'h1);
        req = req & ~gnt;
        step();
        chk("t2_rr_second_2", 32'(gnt), 32'h4);
        req = '0;
        cancel = 4'b0101;
        step();
        cancel = '0;
        chk("t2_cancel_busy", 32'(busy), 32'h0);
        chk("t2_cancel_done", 32'(done), 32'h0);
        chk("t2_pre_zero",    32'(dut.pre_q), 32'h0);

        // 3. Zero duration and mid-phase join
        set_dur(0, 16'd0);
        req = 4'b0001;
        step();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        req = '0;
        wait_done(0, 40, cnt, nt);
        chk("t3_zero_dur_latency", 32'(cnt), 32'd10);

        set_dur(1, 16'd5);
        req = 4'b0010;
        step();
        chk("t3_gnt1", 32'(gnt), 32'h2);
        req = '0;
        repeat (5) step();
        set_dur(2, 16'd1);
        req = 4'b0100;
        step();
        chk("t3_gnt2",     32'(gnt), 32'h4);
        chk("t3_pre_join", 32'(dut.pre_q), 32'd6);
        req = '0;
        wait_done(2, 40, cnt, nt);
        chk("t3_join_latency", 32'(cnt), 32'd4);

        // 4. Cancel races
        repeat (39) step();
        chk("t4_final_tick", 32'(tick), 32'h1);
        chk("t4_busy1",      32'(busy), 32'h2);
        cancel = 4'b0010;
        step();
        cancel = '0;
        chk("t4_cancel_busy", 32'(busy), 32'h0);
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (done !== 4'b0000) seen_done++;
            step();
        end
        chk("t4_no_done", 32'(seen_done), 32'd0);

        set_dur(3, 16'd1);
        cancel = 4'b1000;
        req    = 4'b1000;
        step();
        chk("t4_idle_cancel_gnt",  32'(gnt),  32'h8);
        chk("t4_idle_cancel_busy", 32'(busy), 32'h8);
        cancel = '0;
        req    = '0;
        wait_done(3, 40, cnt, nt);
        chk("t4_ch3_latency", 32'(cnt), 32'd10);
        step();

        // 5. Simultaneous expiry and restart
        set_dur(0, 16'd2);
        set_dur(1, 16'd2);
        req = 4'b0001;
        step();
        chk("t5_gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        step();
        chk("t5_gnt1", 32'(gnt), 32'h2);
        req = '0;
        wait_any_done(40, cnt);
        chk("t5_done_latency", 32'(cnt), 32'd19);
        chk("t5_done_same",    32'(done), 32'h3);
        set_dur(0, 16'd1);
        req = 4'b0001;
        step();
        chk("t5_restart_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_done(0, 40, cnt, nt);
        chk("t5_restart_latency", 32'(cnt), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ms_timer_sched.md
# ms_timer_sched

Four-channel millisecond one-shot timer scheduler built around a single shared millisecond prescaler. Requesters (car light blinkers, debounce windows, motor ramp steps) ask for a delay in whole milliseconds through a round-robin arbitrated load port. The block counts the delays down on the shared tick and returns a one-cycle done pulse per channel. The prescaler runs only while at least one channel is busy.

## Interface
- `T`, default 100000: clock cycles per millisecond. Must be ≥ 2. The prescaler width is $clog2(T).
- `DUR_W`, default 16: width of each channel's duration, in ms.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  4: `req[i]` asks to start channel i. It is held until `gnt[i]` is seen.
- `dur`  in  4*DUR_W: duration for channel i, in ms, at `dur[i*DUR_W +: DUR_W]`. It is sampled at the grant edge.
- `cancel`  in  4: `cancel[i]` aborts a busy channel i.
- `gnt`  out  4: one-hot, one-cycle pulse. Channel i has been loaded.
- `busy`  out  4: channel i is counting.
- `done`  out  4: one-cycle pulse. Channel i has expired.
- `tick`  out  1: one-cycle pulse at each millisecond boundary while any channel is busy.

## Operation
- **Reset.** `gnt`, `busy`, `done` and `tick` are 0. The prescaler is 0. All remaining counters are 0. The round-robin pointer is 3, so channel 0 has the highest priority first.
- **Eligibility.** Channel i is eligible when `req[i]` = 1 and `busy[i]` = 0. A `req` on a busy channel is ignored.
- **Arbitration.** At most one grant per cycle. The block searches round-robin starting at pointer+1 (mod 4) and picks the first eligible channel. At that edge:
  - `gnt[i]` ← 1 and `busy[i]` ← 1.
  - remaining[i] ← `dur` slice. A duration of 0 is loaded as 1.
  - The pointer ← i.
  - `gnt` is registered, so it is high during the cycle after the edge at which the request was sampled.
  - The requester drops `req` after seeing `gnt`. A `req` still high during the `gnt` cycle is ignored because the channel is now busy.
- **Prescaler.**
  - While any channel is busy, the prescaler counts 0..T-1 and wraps.
  - `tick` = 1 exactly when prescaler == T-1 and any channel is busy. It is combinational from registered state and glitch-free relative to `clk`.
  - While all channels are idle, the prescaler is held at 0.
  - When the last busy channel clears, the prescaler is forced to 0 at that same edge.
- **Countdown.** At an edge where `tick` = 1, each busy channel is updated:
  - If remaining > 1: remaining decrements.
  - If remaining == 1: `busy[i]` ← 0 and `done[i]` ← 1 for one cycle.
- **Cancel.**
  - `cancel[i]` with `busy[i]` = 1: `busy[i]` ← 0 at the next edge and no `done`.
  - Cancel wins over expiry in the same cycle.
  - `cancel` on an idle channel is ignored, including in the same cycle as an eligible `req[i]`; the grant proceeds.
- **Grant during tick.** A grant coinciding with a `tick` edge loads the full duration. The newly loaded channel is not decremented by that tick.
- **Restart.** A channel may be re-requested in the cycle its `done` is high. It is eligible because `busy` is already 0.

## Timing
- Grant latency: 1 cycle from `req` sampled to `gnt` high, with no contention.
- Worst-case grant wait with all four contending: 4 cycles.
- Channel started from the all-idle state: `done` rises exactly d·T cycles after the `gnt` cycle, where d = max(`dur`, 1).
- Channel started while others are busy joins mid-phase. `done` rises between (d-1)·T+1 and d·T cycles after `gnt`.
- `done` for channels expiring on the same tick rise in the same cycle.
- `gnt`, `done` and `tick` are never high for more than one consecutive cycle per event.

## Test plan
Use `T` = 10 and `DUR_W` = 16 in simulation.
1. **Reset and single start.** Assert `rst` mid-count, then release. Pulse `req[0]` with `dur0` = 3 → all outputs 0 during reset. `gnt[0]` appears 1 cycle after `req`. `tick` fires 3 times. `done[0]` rises exactly 30 cycles after `gnt[0]`. `busy[0]` falls with it and the prescaler returns to 0.
2. **Contention.** Hold `req` = 4'b1111 from reset, each with `dur` = 2 → `gnt` sequence 0, 1, 2, 3 on consecutive cycles. Then set `req` = 4'b0101 after all four are done → grants go 0 then 2, continuing from pointer 3.
3. **Zero duration and mid-phase join.**
   - `dur0` = 0 → `done[0]` 10 cycles after `gnt[0]`.
   - Start channel 1 (`dur` = 5). At prescaler = 6, start channel 2 (`dur` = 1) → `done[2]` 4 cycles after `gnt[2]`.
4. **Cancel races.**
   - Cancel channel 1 in the cycle its final `tick` is high → `busy[1]` drops and `done[1]` never pulses.
   - `cancel[3]` together with `req[3]` on idle channel 3 → `gnt[3]` still issued.
5. **Simultaneous expiry and restart.**
   - Start channels 0 and 1 back-to-back with `dur` = 2 after a common tick boundary → both `done` in the same cycle.
   - Re-assert `req[0]` during `done[0]` → `gnt[0]` the next cycle.
